// File: rtl/hit_sender.sv
// rtl/hit_sender.sv - buffered hit producer driving a registered-hit consumer via DOUT/CE_OUT
module hit_sender #(
    parameter int HITBITS    = 10,
    parameter int DEPTH_LOG2 = 3,
    parameter int CNTBITS    = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [HITBITS-1:0] WR_DIN,
    input  logic               WR_EN,
    input  logic               WR_EE,
    output logic               FULL,
    output logic               EMPTY,
    input  logic               HOLD,
    output logic [HITBITS-1:0] DOUT,
    output logic               CE_OUT,
    output logic               EE_OUT,
    output logic [CNTBITS-1:0] EVT_CNT,
    output logic               OVERFLOW
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]      PTR_ONE = 1;
    localparam logic [CNTBITS-1:0] CNT_ONE = 1;

    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [HITBITS:0]   r_mem [DEPTH];
    logic [HITBITS-1:0] r_dout;
    logic               r_ce;
    logic               r_ee;
    logic [CNTBITS-1:0] r_evt_cnt;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [HITBITS:0]   w_head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_pop   = !w_empty && !HOLD;
    assign w_wr    = WR_EN && (!w_full || w_pop);
    assign w_drop  = WR_EN && w_full && !w_pop;
    assign w_head  = r_mem[r_rptr[PW-2:0]];

    always_ff @(posedge CLOCK) begin
        if (w_wr) begin
            r_mem[r_wptr[PW-2:0]] <= {WR_EE, WR_DIN};
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_dout     <= '0;
            r_ce       <= 1'b0;
            r_ee       <= 1'b0;
            r_evt_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
                r_dout <= w_head[HITBITS-1:0];
                r_ee   <= w_head[HITBITS];
                r_ce   <= 1'b1;
                if (w_head[HITBITS]) begin
                    r_evt_cnt <= r_evt_cnt + CNT_ONE;
                end
            end else begin
                r_ce <= 1'b0;
                r_ee <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign FULL     = w_full;
    assign EMPTY    = w_empty;
    assign DOUT     = r_dout;
    assign CE_OUT   = r_ce;
    assign EE_OUT   = r_ee;
    assign EVT_CNT  = r_evt_cnt;
    assign OVERFLOW = r_overflow;
endmodule

// File: tb/tb_hit_sender.sv
// tb/tb_hit_sender.sv - self-checking bench for hit_sender against a queue reference model
module tb_hit_sender;
    logic       CLOCK;
    logic       RESET;
    logic [9:0] WR_DIN;
    logic       WR_EN;
    logic       WR_EE;
    logic       FULL;
    logic       EMPTY;
    logic       HOLD;
    logic [9:0] DOUT;
    logic       CE_OUT;
    logic       EE_OUT;
    logic [7:0] EVT_CNT;
    logic       OVERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] mq[$];
    logic [9:0]  m_dout;
    logic        m_ce;
    logic        m_ee;
    logic [7:0]  m_cnt;
    logic        m_ovf;

    typedef struct {
        logic       wr;
        logic [9:0] din;
        logic       ee;
        logic       hold;
        logic       ce;
        logic [9:0] dout;
        logic       eeo;
        logic       empty;
    } vec_t;

    hit_sender #(.HITBITS(10), .DEPTH_LOG2(3), .CNTBITS(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .WR_DIN(WR_DIN), .WR_EN(WR_EN), .WR_EE(WR_EE),
        .FULL(FULL), .EMPTY(EMPTY), .HOLD(HOLD), .DOUT(DOUT), .CE_OUT(CE_OUT),
        .EE_OUT(EE_OUT), .EVT_CNT(EVT_CNT), .OVERFLOW(OVERFLOW)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_dout = '0;
        m_ce   = 1'b0;
        m_ee   = 1'b0;
        m_cnt  = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic chk_model();
        chk("dout", 32'(DOUT), 32'(m_dout));
        chk("ce", 32'(CE_OUT), 32'(m_ce));
        chk("ee", 32'(EE_OUT), 32'(m_ee));
        chk("evt_cnt", 32'(EVT_CNT), 32'(m_cnt));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        chk("full", 32'(FULL), 32'(mq.size() == 8));
        chk("empty", 32'(EMPTY), 32'(mq.size() == 0));
    endtask

    // One clock edge: the model applies the rules to the inputs presented before it.
    task automatic step();
        logic        pop;
        logic        was_full;
        logic        wr;
        logic [10:0] word;
        logic [10:0] h;
        was_full = (mq.size() == 8);
        pop      = (mq.size() != 0) && !HOLD;
        wr       = WR_EN;
        word     = {WR_EE, WR_DIN};
        @(posedge CLOCK);
        #1;
        if (pop) begin
            h      = mq.pop_front();
            m_dout = h[9:0];
            m_ee   = h[10];
            m_ce   = 1'b1;
            if (h[10]) m_cnt = m_cnt + 8'd1;
        end else begin
            m_ce = 1'b0;
            m_ee = 1'b0;
        end
        if (wr) begin
            if (!was_full || pop) mq.push_back(word);
            else m_ovf = 1'b1;
        end
        chk_model();
    endtask

    task automatic set_in(input logic wr, input logic [9:0] din, input logic ee, input logic hold);
        WR_EN  = wr;
        WR_DIN = din;
        WR_EE  = ee;
        HOLD   = hold;
    endtask

    task automatic do_reset();
        @(posedge CLOCK);
        #2;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
            #4;
        end
        model_clear();
        chk("rst_dout", 32'(DOUT), 32'h0);
        chk("rst_ce", 32'(CE_OUT), 32'h0);
        chk("rst_empty", 32'(EMPTY), 32'h1);
        chk("rst_full", 32'(FULL), 32'h0);
        chk("rst_evt_cnt", 32'(EVT_CNT), 32'h0);
        chk("rst_overflow", 32'(OVERFLOW), 32'h0);
        set_in(1'b0, 10'h0, 1'b0, 1'b0);
        RESET = 1'b1;
    endtask

    initial begin
        vec_t vt[5];
        int   pulses;
        logic [9:0] expected_order[$];

        vt[0] = '{1'b1, 10'h001, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vt[1] = '{1'b1, 10'h002, 1'b0, 1'b0, 1'b1, 10'h001, 1'b0, 1'b0};
        vt[2] = '{1'b1, 10'h003, 1'b1, 1'b0, 1'b1, 10'h002, 1'b0, 1'b0};
        vt[3] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h003, 1'b1, 1'b1};
        vt[4] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h003, 1'b0, 1'b1};

        RESET = 1'b0;
        set_in(1'b0, 10'h0, 1'b0, 1'b0);
        model_clear();
        do_reset();

        // Idle after release: no CE.
        for (int i = 0; i < 3; i++) step();

        // Stream of three words, EE on the last.
        for (int i = 0; i < 5; i++) begin
            set_in(vt[i].wr, vt[i].din, vt[i].ee, vt[i].hold);
            step();
            chk("vec_ce", 32'(CE_OUT), 32'(vt[i].ce));
            chk("vec_dout", 32'(DOUT), 32'(vt[i].dout));
            chk("vec_ee", 32'(EE_OUT), 32'(vt[i].eeo));
            chk("vec_empty", 32'(EMPTY), 32'(vt[i].empty));
        end
        chk("stream_evt_cnt", 32'(EVT_CNT), 32'h1);

        // Back-pressure: fill under HOLD, overflow on the 9th, then drain.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 10'(10'h100 + i), 1'b0, 1'b1);
            step();
            chk("bp_ce_low", 32'(CE_OUT), 32'h0);
        end
        chk("bp_full", 32'(FULL), 32'h1);
        chk("bp_overflow", 32'(OVERFLOW), 32'h1);
        set_in(1'b0, 10'h0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (CE_OUT) begin
                chk("bp_order", 32'(DOUT), 32'(10'h100 + pulses));
                pulses++;
            end
        end
        chk("bp_pulses", 32'(pulses), 32'd8);

        // Full buffer with a write and a pop every cycle.
        do_reset();
        expected_order.delete();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 10'(10'h200 + i), 1'b0, 1'b1);
            expected_order.push_back(10'(10'h200 + i));
            step();
        end
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 10'(10'h300 + i), 1'b0, 1'b0);
            expected_order.push_back(10'(10'h300 + i));
            step();
            chk("fw_ce", 32'(CE_OUT), 32'h1);
            chk("fw_full", 32'(FULL), 32'h1);
            chk("fw_overflow", 32'(OVERFLOW), 32'h0);
            chk("fw_order", 32'(DOUT), 32'(expected_order.pop_front()));
        end

        // Event counter wrap after 256 EE words.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            set_in(1'b1, 10'($urandom), 1'b1, 1'b0);
            step();
        end
        set_in(1'b0, 10'h0, 1'b0, 1'b0);
        step();
        chk("wrap_evt_cnt", 32'(EVT_CNT), 32'h0);
        step();
        chk("wrap_empty", 32'(EMPTY), 32'h1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 10'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 2) == 0));
            step();
        end

        // Mid-operation reset with five words buffered.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 10'(10'h050 + i), 1'b1, 1'b1);
            step();
        end
        set_in(1'b0, 10'h0, 1'b0, 1'b0);
        step();
        chk("mid_pre_ce", 32'(CE_OUT), 32'h1);
        set_in(1'b0, 10'h0, 1'b0, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        model_clear();
        chk("mid_dout", 32'(DOUT), 32'h0);
        chk("mid_ce", 32'(CE_OUT), 32'h0);
        chk("mid_ee", 32'(EE_OUT), 32'h0);
        chk("mid_empty", 32'(EMPTY), 32'h1);
        chk("mid_evt_cnt", 32'(EVT_CNT), 32'h0);
        RESET = 1'b1;
        HOLD  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_ce", 32'(CE_OUT), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
